pong_engine: RTL and testbench

Parametrised single-player ball/paddle game engine with one-pixel-per-cycle plot output for the 160x120 VGA adapter path. Moves a BALL_SIZE x BALL_SIZE ball in 2D with wall and paddle bounces, a PADDLE_W-wide paddle, miss detection, score and lives. Includes its own frame-rate divider and a pause mode. Sits between the board keys and `vga_adapter`; its x/y/colour/plot outputs drive the adapter directly.

---
 rtl/pong_pkg.sv | 18 +
 rtl/frame_tick.sv | 25 ++
 rtl/pong_engine.sv | 214 +++++++++++++++++++++
 tb/tb_pong_engine.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// State encoding and pixel colours shared by the pong engine.
package pong_pkg;

  typedef enum logic [2:0] {
    WAIT,
    ERASE_BALL,
    ERASE_PADDLE,
    UPDATE,
    DRAW_BALL,
    DRAW_PADDLE,
    OVER
  } state_t;

  localparam logic [2:0] COL_BG     = 3'b000;
  localparam logic [2:0] COL_BALL   = 3'b111;
  localparam logic [2:0] COL_PADDLE = 3'b010;

endpackage

// File: rtl/frame_tick.sv
// Free-running frame divider: tick is high for one cycle every FRAME_DIV clocks.
module frame_tick #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(FRAME_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pong_engine.sv
// Single-player pong engine: erase, update and redraw of ball and paddle on each accepted frame tick.
// Pixel outputs are computed from next-state so plot/x/y/colour line up with the pixel states.
module pong_engine
  import pong_pkg::*;
#(
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int BALL_SIZE = 2,
  parameter int PADDLE_W  = 16,
  parameter int PADDLE_Y  = 110,
  parameter int FRAME_DIV = 833333,
  parameter int LIVES     = 3,
  parameter int SCORE_W   = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         left,
  input  logic                         right,
  input  logic                         pause,
  output logic [$clog2(SCREEN_W)-1:0]  x,
  output logic [$clog2(SCREEN_H)-1:0]  y,
  output logic [2:0]                   colour,
  output logic                         plot,
  output logic [SCORE_W-1:0]           score,
  output logic [$clog2(LIVES+1)-1:0]   lives,
  output logic                         game_over,
  output logic                         frame_overrun
);

  localparam int XW   = $clog2(SCREEN_W);
  localparam int YW   = $clog2(SCREEN_H);
  localparam int LW   = $clog2(LIVES + 1);
  localparam int CMAX = (PADDLE_W > BALL_SIZE) ? PADDLE_W : BALL_SIZE;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int BX0  = (SCREEN_W - BALL_SIZE) / 2;
  localparam int BY0  = PADDLE_Y / 2;
  localparam int PX0  = (SCREEN_W - PADDLE_W) / 2;

  state_t          state_q, state_d;
  logic [CW-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic [XW-1:0]   bx_q, bx_d, px_q, px_d, x_q, x_d;
  logic [YW-1:0]   by_q, by_d, y_q, y_d;
  logic            dir_r_q, dir_r_d, dir_d_q, dir_d_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LW-1:0]   lives_q, lives_d;
  logic            over_q, over_d, plot_q, plot_d, ovr_q, ovr_d;
  logic [2:0]      colour_q, colour_d;
  logic            tick, ball_last, pad_last, nr, nd, hit, miss;

  frame_tick #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  always_comb begin
    state_d  = state_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    bx_d     = bx_q;
    by_d     = by_q;
    px_d     = px_q;
    dir_r_d  = dir_r_q;
    dir_d_d  = dir_d_q;
    score_d  = score_q;
    lives_d  = lives_q;
    over_d   = over_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    nr       = dir_r_q;
    nd       = dir_d_q;
    hit      = 1'b0;
    miss     = 1'b0;
    ovr_d    = tick && (state_q != WAIT) && (state_q != OVER);
    ball_last = (int'(dx_q) == BALL_SIZE - 1) && (int'(dy_q) == BALL_SIZE - 1);
    pad_last  = (int'(dx_q) == PADDLE_W - 1);

    case (state_q)
      WAIT: begin
        if (tick && !pause) begin
          state_d = ERASE_BALL;
          dx_d    = '0;
          dy_d    = '0;
        end
      end
      // plot_q low inside a pixel state only right after reset: emit pixel (0,0) first
      ERASE_BALL, DRAW_BALL: begin
        if (plot_q) begin
          if (ball_last) begin
            state_d = (state_q == ERASE_BALL) ? ERASE_PADDLE : DRAW_PADDLE;
            dx_d    = '0;
            dy_d    = '0;
          end else if (int'(dx_q) == BALL_SIZE - 1) begin
            dx_d = '0;
            dy_d = dy_q + CW'(1);
          end else begin
            dx_d = dx_q + CW'(1);
          end
        end
      end
      ERASE_PADDLE, DRAW_PADDLE: begin
        if (plot_q) begin
          if (pad_last) begin
            dx_d = '0;
            if (state_q == ERASE_PADDLE) state_d = UPDATE;
            else                         state_d = over_q ? OVER : WAIT;
          end else begin
            dx_d = dx_q + CW'(1);
          end
        end
      end
      UPDATE: begin
        if (left && !right && px_q != '0)
          px_d = px_q - XW'(1);
        else if (right && !left && int'(px_q) < SCREEN_W - PADDLE_W)
          px_d = px_q + XW'(1);
        if (!dir_r_q && bx_q == '0)                           nr = 1'b1;
        if (dir_r_q && int'(bx_q) == SCREEN_W - BALL_SIZE)    nr = 1'b0;
        if (!dir_d_q && by_q == '0)                           nd = 1'b1;
        hit  = dir_d_q && (int'(by_q) + BALL_SIZE == PADDLE_Y) &&
               (int'(bx_q) + BALL_SIZE - 1 >= int'(px_q)) &&
               (int'(bx_q) <= int'(px_q) + PADDLE_W - 1);
        miss = dir_d_q && (int'(by_q) + BALL_SIZE == SCREEN_H);
        if (hit) begin
          nd = 1'b0;
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
        end
        if (miss) begin
          if (lives_q != '0)        lives_d = lives_q - LW'(1);
          if (lives_q == LW'(1))    over_d  = 1'b1;
          bx_d    = XW'(BX0);
          by_d    = YW'(BY0);
          dir_r_d = 1'b1;
          dir_d_d = 1'b1;
        end else begin
          dir_r_d = nr;
          dir_d_d = nd;
          bx_d    = nr ? bx_q + XW'(1) : bx_q - XW'(1);
          by_d    = nd ? by_q + YW'(1) : by_q - YW'(1);
        end
        state_d = over_d ? DRAW_PADDLE : DRAW_BALL;
        dx_d    = '0;
        dy_d    = '0;
      end
      default: ;
    endcase

    case (state_d)
      ERASE_BALL, DRAW_BALL: begin
        plot_d   = 1'b1;
        x_d      = XW'(int'(bx_d) + int'(dx_d));
        y_d      = YW'(int'(by_d) + int'(dy_d));
        colour_d = (state_d == DRAW_BALL) ? COL_BALL : COL_BG;
      end
      ERASE_PADDLE, DRAW_PADDLE: begin
        plot_d   = 1'b1;
        x_d      = XW'(int'(px_d) + int'(dx_d));
        y_d      = YW'(PADDLE_Y);
        colour_d = (state_d == DRAW_PADDLE) ? COL_PADDLE : COL_BG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DRAW_BALL;
      dx_q     <= '0;
      dy_q     <= '0;
      bx_q     <= XW'(BX0);
      by_q     <= YW'(BY0);
      px_q     <= XW'(PX0);
      dir_r_q  <= 1'b1;
      dir_d_q  <= 1'b1;
      score_q  <= '0;
      lives_q  <= LW'(LIVES);
      over_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= COL_BG;
      plot_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      px_q     <= px_d;
      dir_r_q  <= dir_r_d;
      dir_d_q  <= dir_d_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      over_q   <= over_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      ovr_q    <= ovr_d;
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign colour        = colour_q;
  assign plot          = plot_q;
  assign score         = score_q;
  assign lives         = lives_q;
  assign game_over     = over_q;
  assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: frame-step vector tables plus reset, latency and overrun sequences.
`timescale 1ns/1ps
module tb_pong_engine;

  localparam int FD = 200;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic left = 1'b0, right = 1'b0, pause = 1'b0;

  logic [7:0] x;  logic [6:0] y;  logic [2:0] colour;  logic plot;
  logic [7:0] score;  logic [1:0] lives;  logic game_over, frame_overrun;

  logic [7:0] fx; logic [6:0] fy; logic [2:0] fcol; logic fplot;
  logic [7:0] fscore; logic [1:0] flives; logic fgo, fovr;

  always #10 clk = ~clk;

  pong_engine #(.FRAME_DIV(FD)) dut (
    .clk(clk), .resetn(resetn), .left(left), .right(right), .pause(pause),
    .x(x), .y(y), .colour(colour), .plot(plot), .score(score), .lives(lives),
    .game_over(game_over), .frame_overrun(frame_overrun)
  );

  // Frame period shorter than a frame, so ticks land mid-frame.
  pong_engine #(.FRAME_DIV(30)) dut_fast (
    .clk(clk), .resetn(resetn), .left(left), .right(right), .pause(pause),
    .x(fx), .y(fy), .colour(fcol), .plot(fplot), .score(fscore), .lives(flives),
    .game_over(fgo), .frame_overrun(fovr)
  );

  int n_cmp = 0, n_bad = 0;
  int win_plots = 0, win_ovr = 0;
  int mon_bx = -1, mon_by = -1, mon_px = -1;
  int npx = 0;
  int pix_x [64];
  int pix_y [64];
  int pix_c [64];
  logic       prev_plot = 1'b0;
  logic [2:0] prev_col = 3'b000;
  int fovr_cnt = 0, fovr_run = 0, fovr_max = 0;

  always @(negedge clk) begin
    if (plot) begin
      win_plots++;
      if (colour == 3'b111 && !(prev_plot && prev_col == 3'b111)) begin
        mon_bx = int'(x);
        mon_by = int'(y);
      end
      if (colour == 3'b010 && !(prev_plot && prev_col == 3'b010)) mon_px = int'(x);
      if (npx < 64) begin
        pix_x[npx] = int'(x);
        pix_y[npx] = int'(y);
        pix_c[npx] = int'(colour);
        npx++;
      end
    end
    if (frame_overrun) win_ovr++;
    prev_plot = plot;
    prev_col  = colour;
    if (fovr) begin
      fovr_run++;
      if (fovr_run == 1) fovr_cnt++;
      if (fovr_run > fovr_max) fovr_max = fovr_run;
    end else begin
      fovr_run = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int n; int l; int r; int p;
    int bx; int by; int px; int sc; int lv; int go; int plots;
  } vec_t;

  vec_t tbl_a [5];
  vec_t tbl_b [11];

  task automatic run_vec(input vec_t v, input string tag);
    left  = (v.l != 0);
    right = (v.r != 0);
    pause = (v.p != 0);
    win_plots = 0;
    win_ovr   = 0;
    repeat (v.n * FD) @(posedge clk);
    #1;
    chk({tag, "_bx"},    mon_bx,       v.bx);
    chk({tag, "_by"},    mon_by,       v.by);
    chk({tag, "_px"},    mon_px,       v.px);
    chk({tag, "_score"}, int'(score),  v.sc);
    chk({tag, "_lives"}, int'(lives),  v.lv);
    chk({tag, "_over"},  int'(game_over), v.go);
    chk({tag, "_plots"}, win_plots,    v.plots);
    chk({tag, "_ovr"},   win_ovr,      0);
  endtask

  // Release reset just after an edge and align to mid-frame (counter near 100).
  task automatic restart();
    npx = 0;
    resetn = 1'b1;
    repeat (100) @(posedge clk);
    #1;
  endtask

  task automatic check_initial_draw(input string tag);
    int ex, ey, ec;
    chk({tag, "_npx"}, npx, 20);
    for (int i = 0; i < 20; i++) begin
      if (i < 4) begin ex = 79 + i % 2; ey = 55 + i / 2; ec = 7; end
      else       begin ex = 72 + i - 4; ey = 110;        ec = 2; end
      chk($sformatf("%s_pix%0d", tag, i),
          (pix_x[i] * 256 + pix_y[i]) * 8 + pix_c[i], (ex * 256 + ey) * 8 + ec);
    end
  endtask

  initial begin
    bit found;
    int last, cnt;

    // n  l  r  p   bx   by   px  sc lv go plots
    tbl_a[0] = '{45, 0, 1, 0, 124, 100, 117, 0, 3, 0, 1800};
    tbl_a[1] = '{ 9, 0, 0, 0, 133, 107, 117, 1, 3, 0,  360};
    tbl_a[2] = '{25, 0, 0, 0, 158,  82, 117, 1, 3, 0, 1000};
    tbl_a[3] = '{ 1, 0, 0, 0, 157,  81, 117, 1, 3, 0,   40};
    tbl_a[4] = '{ 2, 1, 1, 0, 155,  79, 117, 1, 3, 0,   80};

    tbl_b[0]  = '{ 3, 1, 1, 0,  82,  58,  72, 0, 3, 0,  120};
    tbl_b[1]  = '{44, 0, 1, 0, 126, 102, 116, 0, 3, 0, 1760};
    tbl_b[2]  = '{16, 0, 0, 0, 142, 118, 116, 0, 3, 0,  640};
    tbl_b[3]  = '{ 1, 0, 0, 0,  79,  55, 116, 0, 2, 0,   40};
    tbl_b[4]  = '{60, 1, 0, 0, 139, 115,  56, 0, 2, 0, 2400};
    tbl_b[5]  = '{ 3, 1, 0, 1, 139, 115,  56, 0, 2, 0,    0};
    tbl_b[6]  = '{ 4, 1, 0, 0,  79,  55,  52, 0, 1, 0,  160};
    tbl_b[7]  = '{60, 1, 0, 0, 139, 115,   0, 0, 1, 0, 2400};
    tbl_b[8]  = '{ 3, 1, 0, 0, 142, 118,   0, 0, 1, 0,  120};
    tbl_b[9]  = '{ 1, 0, 0, 0, 142, 118,   0, 0, 0, 1,   36};
    tbl_b[10] = '{ 5, 0, 0, 0, 142, 118,   0, 0, 0, 1,    0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_plot",   int'(plot),   0);
    chk("rst_x",      int'(x),      0);
    chk("rst_y",      int'(y),      0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_score",  int'(score),  0);
    chk("rst_lives",  int'(lives),  3);
    chk("rst_over",   int'(game_over), 0);
    chk("rst_ovr",    int'(frame_overrun), 0);

    restart();
    check_initial_draw("init");

    // Paddle edge hit, right-wall bounce, both-keys hold.
    for (int i = 0; i < 5; i++) run_vec(tbl_a[i], $sformatf("A%0d", i));

    // Tick-to-last-pixel latency of a full frame.
    left = 1'b0; right = 1'b0; pause = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (plot) found = 1'b1;
    end
    chk("lat_found", int'(found), 1);
    last = 0; cnt = 1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (plot) begin last = i; cnt++; end
    end
    chk("lat_tick_to_last", last + 1, 41);
    chk("lat_frame_plots",  cnt, 40);

    // Async reset in the middle of DRAW_PADDLE.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      if (plot && colour == 3'b010) found = 1'b1;
    end
    chk("midrst_found", int'(found), 1);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("midrst_plot",   int'(plot),   0);
    chk("midrst_x",      int'(x),      0);
    chk("midrst_y",      int'(y),      0);
    chk("midrst_colour", int'(colour), 0);
    chk("midrst_score",  int'(score),  0);
    chk("midrst_lives",  int'(lives),  3);

    chk("fast_ovr_seen",  int'(fovr_cnt > 0), 1);
    chk("fast_ovr_width", fovr_max, 1);

    repeat (2) @(posedge clk);
    #1;
    restart();
    check_initial_draw("reinit");

    // Near-miss, misses, pause, left saturation, game over and OVER silence.
    for (int i = 0; i < 11; i++) run_vec(tbl_b[i], $sformatf("B%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
